status_register_unit: RTL and testbench

//  Producer side of the condition-code path. Holds the architectural CPSR

---
 rtl/arm_pkg.sv | 26 ++
 rtl/flag_scoreboard.sv | 63 ++++++
 rtl/status_register_unit.sv | 74 +++++++
 tb/tb_status_register_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM condition-code definitions: NZCV bit positions and the 4-bit cond field
// encodings used by both the flag producer and the ID-stage condition checker.
package arm_pkg;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/flag_scoreboard.sv
// Counts flag-writing instructions in flight between ID issue and EXE retire and
// decides whether a conditional instruction in ID must stall or can take bypassed flags.
module flag_scoreboard #(
    parameter int MAX_PENDING = 3,
    parameter int FORWARD     = 1,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_issue_s,
    input  logic              id_needs_flags,
    input  logic              exe_valid,
    input  logic              exe_s,
    input  logic              exe_cond_pass,
    input  logic              msr_we,
    input  logic              flush,
    output logic              flags_hazard,
    output logic              bypass,
    output logic [PEND_W-1:0] pending,
    output logic              ovf_err
);

    logic [PEND_W-1:0] pending_q, pending_d;
    logic              ovf_q, ovf_d;
    logic              retire, issue, empty, at_max;

    always_comb begin
        retire = exe_valid & exe_s;
        empty  = (pending_q == '0);
        at_max = (pending_q == PEND_W'(MAX_PENDING));
        // Only the last outstanding writer can be bypassed; an MSR in the same cycle
        // makes the ALU merge stale, so it blocks forwarding.
        bypass = (FORWARD != 0) & retire & exe_cond_pass
                 & (pending_q == PEND_W'(1)) & ~msr_we;
        flags_hazard = id_needs_flags & ~empty & ~bypass;
        issue = id_issue_s & ~flags_hazard;

        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (flush) begin
            pending_d = '0;
        end else if (issue && !retire) begin
            if (at_max) ovf_d = 1'b1;
            else        pending_d = pending_q + 1'b1;
        end else if (retire && !issue && !empty) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pending = pending_q;
    assign ovf_err = ovf_q;

endmodule

// File: rtl/status_register_unit.sv
// Architectural NZCV register: updated from EXE ALU results or MSR, and presented
// (optionally bypassed) to the ID-stage condition checker with stall control.
module status_register_unit
    import arm_pkg::*;
#(
    parameter int MAX_PENDING = 3,
    parameter int FORWARD     = 1,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_issue_s,
    input  logic              id_needs_flags,
    input  logic              exe_valid,
    input  logic              exe_s,
    input  logic              exe_cond_pass,
    input  logic [3:0]        exe_flag_mask,
    input  logic [3:0]        alu_nzcv,
    input  logic              msr_we,
    input  logic [3:0]        msr_data,
    input  logic              flush,
    output logic [3:0]        status,
    output logic [3:0]        status_cc,
    output logic              flags_hazard,
    output logic [PEND_W-1:0] pending,
    output logic              ovf_err
);

    logic [3:0] status_q, status_d;
    logic [3:0] alu_merge;
    logic       bypass;

    // Per-flag select: masked bits take the ALU value, the rest keep the current flag.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign alu_merge[gi] = exe_flag_mask[gi] ? alu_nzcv[gi] : status_q[gi];
    end

    always_comb begin
        status_d = status_q;
        if (msr_we)
            status_d = msr_data;
        else if (exe_valid && exe_s && exe_cond_pass)
            status_d = alu_merge;
    end

    always_ff @(posedge clk) begin
        if (rst) status_q <= 4'b0000;
        else     status_q <= status_d;
    end

    flag_scoreboard #(
        .MAX_PENDING (MAX_PENDING),
        .FORWARD     (FORWARD),
        .PEND_W      (PEND_W)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .id_issue_s     (id_issue_s),
        .id_needs_flags (id_needs_flags),
        .exe_valid      (exe_valid),
        .exe_s          (exe_s),
        .exe_cond_pass  (exe_cond_pass),
        .msr_we         (msr_we),
        .flush          (flush),
        .flags_hazard   (flags_hazard),
        .bypass         (bypass),
        .pending        (pending),
        .ovf_err        (ovf_err)
    );

    assign status    = status_q;
    assign status_cc = bypass ? alu_merge : status_q;

endmodule

// File: tb/tb_status_register_unit.sv
// Drives a forwarding and a non-forwarding instance with the same stimulus and
// compares both against a cycle-level reference model of the flag/stall rules.
module tb_status_register_unit;

    logic       clk = 1'b0;
    logic       rst, id_issue_s, id_needs_flags, exe_valid, exe_s, exe_cond_pass;
    logic [3:0] exe_flag_mask, alu_nzcv, msr_data;
    logic       msr_we, flush;

    logic [3:0] status_f, status_cc_f, status_n, status_cc_n;
    logic       flags_hazard_f, flags_hazard_n, ovf_err_f, ovf_err_n;
    logic [1:0] pending_f, pending_n;

    int total = 0;
    int bad   = 0;

    // reference state, index 0 = FORWARD=1 instance, 1 = FORWARD=0 instance
    logic [3:0] m_stat [2];
    int         m_pend [2];
    bit         m_ovf  [2];

    always #5 clk = ~clk;

    status_register_unit #(.MAX_PENDING(3), .FORWARD(1), .PEND_W(2)) dut_f (
        .clk(clk), .rst(rst), .id_issue_s(id_issue_s), .id_needs_flags(id_needs_flags),
        .exe_valid(exe_valid), .exe_s(exe_s), .exe_cond_pass(exe_cond_pass),
        .exe_flag_mask(exe_flag_mask), .alu_nzcv(alu_nzcv), .msr_we(msr_we),
        .msr_data(msr_data), .flush(flush), .status(status_f), .status_cc(status_cc_f),
        .flags_hazard(flags_hazard_f), .pending(pending_f), .ovf_err(ovf_err_f));

    status_register_unit #(.MAX_PENDING(3), .FORWARD(0), .PEND_W(2)) dut_n (
        .clk(clk), .rst(rst), .id_issue_s(id_issue_s), .id_needs_flags(id_needs_flags),
        .exe_valid(exe_valid), .exe_s(exe_s), .exe_cond_pass(exe_cond_pass),
        .exe_flag_mask(exe_flag_mask), .alu_nzcv(alu_nzcv), .msr_we(msr_we),
        .msr_data(msr_data), .flush(flush), .status(status_n), .status_cc(status_cc_n),
        .flags_hazard(flags_hazard_n), .pending(pending_n), .ovf_err(ovf_err_n));

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 0; id_issue_s = 0; id_needs_flags = 0; exe_valid = 0; exe_s = 0;
        exe_cond_pass = 0; exe_flag_mask = 4'h0; alu_nzcv = 4'h0;
        msr_we = 0; msr_data = 4'h0; flush = 0;
    endtask

    task automatic retire_op(input logic pass, input logic [3:0] mask, input logic [3:0] alu);
        exe_valid = 1; exe_s = 1; exe_cond_pass = pass; exe_flag_mask = mask; alu_nzcv = alu;
    endtask

    // Checks current outputs of both instances against the model, then advances one clock.
    task automatic cycle();
        logic [3:0] merged, cc, obs_st, obs_cc, ns;
        bit         retire, byp, haz, iss, no;
        int         np;
        string      pfx;
        #1;
        for (int k = 0; k < 2; k++) begin
            pfx    = (k == 0) ? "fwd" : "nofwd";
            obs_st = (k == 0) ? status_f : status_n;
            obs_cc = (k == 0) ? status_cc_f : status_cc_n;
            merged = (alu_nzcv & exe_flag_mask) | (m_stat[k] & ~exe_flag_mask);
            retire = exe_valid && exe_s;
            byp    = (k == 0) && retire && exe_cond_pass && m_pend[k] == 1 && !msr_we;
            haz    = id_needs_flags && m_pend[k] != 0 && !byp;
            cc     = byp ? merged : m_stat[k];
            check_val({pfx, ".status"}, 8'(obs_st), 8'(m_stat[k]));
            check_val({pfx, ".status_cc"}, 8'(obs_cc), 8'(cc));
            check_val({pfx, ".hazard"}, 8'((k == 0) ? flags_hazard_f : flags_hazard_n), 8'(haz));
            check_val({pfx, ".pending"}, 8'((k == 0) ? pending_f : pending_n), 8'(m_pend[k]));
            check_val({pfx, ".ovf_err"}, 8'((k == 0) ? ovf_err_f : ovf_err_n), 8'(m_ovf[k]));
            if (rst) begin
                ns = 4'h0; np = 0; no = 0;
            end else begin
                ns = m_stat[k];
                if (msr_we) ns = msr_data;
                else if (retire && exe_cond_pass) ns = merged;
                iss = id_issue_s && !haz;
                np  = m_pend[k];
                no  = m_ovf[k];
                if (flush) np = 0;
                else if (iss && retire) np = np;
                else if (iss) begin
                    if (np == 3) no = 1;
                    else np = np + 1;
                end else if (retire && np > 0) np = np - 1;
            end
            m_stat[k] = ns; m_pend[k] = np; m_ovf[k] = no;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_stat[k] = 4'h0; m_pend[k] = 0; m_ovf[k] = 0;
        end
        idle();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        cycle();
        idle();
        #1;
        check_val("reset.status", 8'(status_f), 8'h00);
        check_val("reset.pending", 8'(pending_f), 8'h00);
        check_val("reset.hazard", 8'(flags_hazard_f), 8'h00);
        check_val("reset.ovf_err", 8'(ovf_err_f), 8'h00);

        retire_op(1, 4'b1111, 4'b1001); cycle();
        check_val("upd.full", 8'(status_f), 8'b1001);
        idle(); retire_op(1, 4'b1100, 4'b0110); cycle();
        check_val("upd.mask", 8'(status_f), 8'b0101);

        idle(); id_issue_s = 1; cycle();
        idle(); retire_op(0, 4'b1111, 4'b1111); cycle();
        check_val("condfail.status", 8'(status_f), 8'b0101);
        check_val("condfail.pending", 8'(pending_f), 8'h00);

        idle(); id_issue_s = 1; cycle();
        idle(); id_needs_flags = 1; #1;
        check_val("haz.wait_f", 8'(flags_hazard_f), 8'h01);
        check_val("haz.wait_n", 8'(flags_hazard_n), 8'h01);
        cycle();
        id_needs_flags = 1; retire_op(1, 4'b1111, 4'b1010); #1;
        check_val("haz.retire_f", 8'(flags_hazard_f), 8'h00);
        check_val("haz.bypass_cc", 8'(status_cc_f), 8'b1010);
        check_val("haz.retire_n", 8'(flags_hazard_n), 8'h01);
        check_val("haz.nobypass_cc", 8'(status_cc_n), 8'b0101);
        cycle();
        idle(); id_needs_flags = 1; #1;
        check_val("haz.after_n", 8'(flags_hazard_n), 8'h00);
        check_val("haz.pending_n", 8'(pending_n), 8'h00);
        cycle();

        idle(); msr_we = 1; msr_data = 4'b0010; retire_op(1, 4'b1111, 4'b1101); cycle();
        check_val("msr.override", 8'(status_f), 8'b0010);

        idle(); id_issue_s = 1;
        repeat (3) cycle();
        check_val("ovf.full", 8'(pending_f), 8'h03);
        cycle();
        check_val("ovf.pending", 8'(pending_f), 8'h03);
        check_val("ovf.sticky", 8'(ovf_err_f), 8'h01);
        idle(); flush = 1; cycle();
        check_val("flush.pending", 8'(pending_f), 8'h00);
        check_val("flush.ovf", 8'(ovf_err_f), 8'h01);
        idle(); rst = 1; cycle();
        check_val("rst.ovf", 8'(ovf_err_f), 8'h00);

        for (int i = 0; i < 600; i++) begin
            idle();
            rst            = ($urandom_range(0, 59) == 0);
            flush          = ($urandom_range(0, 15) == 0);
            id_issue_s     = ($urandom_range(0, 2) == 0);
            id_needs_flags = $urandom_range(0, 1);
            exe_valid      = $urandom_range(0, 1);
            exe_s          = ($urandom_range(0, 2) != 0);
            exe_cond_pass  = ($urandom_range(0, 3) != 0);
            exe_flag_mask  = 4'($urandom);
            alu_nzcv       = 4'($urandom);
            msr_we         = ($urandom_range(0, 7) == 0);
            msr_data       = 4'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
